adder_sched: RTL and testbench

- Sequencer and arbiter for the shared 8-bit ripple `Adder`.
- Two requesters submit NBYTES-byte add/subtract operations.
- The block grants one requester round-robin, drives the single `Adder` instance one byte per cycle (LSB first, carry chained through a register), and returns the wide result with flags over a valid/ready handshake.
- Sits between the arithmetic clients and the `Adder`; no other block instantiates the adder.

---
 rtl/adder_sched_if.sv | 34 +++
 rtl/adder_sched.sv | 137 +++++++++++++
 tb/tb_adder_sched.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_sched_if.sv
// adder_sched_if: request/result bundle between the arithmetic clients and
// the shared-adder sequencer.
//   req_valid/req_ready : per-requester handshake (2 requesters)
//   req_a/req_b         : operands, requester i at [i*W +: W]
//   req_sub             : per-requester 1 = A-B, 0 = A+B
//   res_*               : result with carry/overflow flags and requester id
// master = client side, slave = adder_sched.
interface adder_sched_if #(
   parameter int NBYTES = 2
);
   localparam int W = 8 * NBYTES;

   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [2*W-1:0] req_a;
   logic [2*W-1:0] req_b;
   logic [1:0]     req_sub;
   logic           res_valid;
   logic           res_ready;
   logic [W-1:0]   res_sum;
   logic           res_cout;
   logic           res_ovf;
   logic           res_id;

   modport master (
      output req_valid, req_a, req_b, req_sub, res_ready,
      input  req_ready, res_valid, res_sum, res_cout, res_ovf, res_id
   );

   modport slave (
      input  req_valid, req_a, req_b, req_sub, res_ready,
      output req_ready, res_valid, res_sum, res_cout, res_ovf, res_id
   );
endinterface

// File: rtl/adder_sched.sv
// adder_sched: round-robin arbiter and byte-serial sequencer for the single
// shared 8-bit ripple adder. A granted W-bit add/subtract is computed one
// byte per cycle (LSB first) with the carry chained through a register, and
// the result is returned over a valid/ready handshake.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : adder_sched_if.slave (request and result channels)
// Contains adder_sched_add8, the 8-bit ripple adder instantiated once here.

module adder_sched_add8 (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       cin_i,
   output logic [7:0] sum_o,
   output logic       cout_o
);
   logic c;

   always_comb begin
      c     = cin_i;
      sum_o = '0;
      for (int i = 0; i < 8; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ c;
         c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
      end
      cout_o = c;
   end
endmodule

module adder_sched #(
   parameter int NBYTES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   adder_sched_if.slave bus
);
   localparam int W  = 8 * NBYTES;
   localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state_q;
   logic          rr_q;
   logic [CW-1:0] cnt_q;
   logic          carry_q;
   logic [W-1:0]  a_q, b_q, sum_q;
   logic          sub_q, id_q, cout_q, ovf_q, valid_q;

   // ---- arbitration (combinational, only meaningful in IDLE) ----
   logic       gnt_any, gnt_id;
   logic [1:0] ready;

   always_comb begin
      gnt_any = |bus.req_valid;
      gnt_id  = bus.req_valid[rr_q] ? rr_q : ~rr_q;
      ready   = '0;
      if (state_q == IDLE && gnt_any) ready[gnt_id] = 1'b1;
   end

   assign bus.req_ready = ready;

   // ---- byte slice for the current pass ----
   logic [7:0] a_byte, b_byte, add_sum;
   logic       add_cin, add_cout, last_pass;

   assign a_byte    = a_q[8*cnt_q +: 8];
   // Subtract = A + ~B + 1: invert B here, the +1 enters as pass-0 carry-in.
   assign b_byte    = b_q[8*cnt_q +: 8] ^ {8{sub_q}};
   assign add_cin   = (cnt_q == '0) ? sub_q : carry_q;
   assign last_pass = (cnt_q == CW'(NBYTES - 1));

   adder_sched_add8 u_add (
      .a_i    (a_byte),
      .b_i    (b_byte),
      .cin_i  (add_cin),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   // ---- FSM with registered outputs ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         sub_q   <= 1'b0;
         id_q    <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt_any) begin
                  a_q     <= gnt_id ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
                  b_q     <= gnt_id ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
                  sub_q   <= bus.req_sub[gnt_id];
                  id_q    <= gnt_id;
                  cnt_q   <= '0;
                  state_q <= CALC;
               end
            end
            CALC: begin
               sum_q[8*cnt_q +: 8] <= add_sum;
               carry_q             <= add_cout;
               if (last_pass) begin
                  cout_q  <= add_cout;
                  // carry into MSB = a ^ b' ^ sum at bit W-1; ovf = that ^ cout
                  ovf_q   <= a_byte[7] ^ b_byte[7] ^ add_sum[7] ^ add_cout;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (bus.res_ready) begin
                  valid_q <= 1'b0;
                  rr_q    <= ~id_q;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.res_valid = valid_q;
   assign bus.res_sum   = sum_q;
   assign bus.res_cout  = cout_q;
   assign bus.res_ovf   = ovf_q;
   assign bus.res_id    = id_q;
endmodule

// File: tb/tb_adder_sched.sv
// tb_adder_sched: directed self-checking bench for adder_sched, NBYTES=2.
module tb_adder_sched;
   localparam int NB = 2;
   localparam int W  = 8 * NB;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   adder_sched_if #(.NBYTES(NB)) bus ();

   adder_sched #(.NBYTES(NB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   task automatic set_slot(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      bus.req_a[int'(id)*W +: W] = a;
      bus.req_b[int'(id)*W +: W] = b;
      bus.req_sub[id]            = sub;
   endtask

   // Drives one request from requester id until handshake, scrambles its
   // inputs afterwards, and returns the cycle count until res_valid
   // (handshake cycle T -> first negedge of T+1 counts as 1). -1 on timeout.
   task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, output int lat);
      bit got;
      int n;
      lat = -1;
      got = 0;
      @(posedge clk); #1;
      set_slot(id, a, b, sub);
      bus.req_valid[id] = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (bus.req_ready[id]) got = 1;
         else begin @(posedge clk); #1; end
      end
      if (!got) begin
         bus.req_valid[id] = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.req_valid[id] = 1'b0;
      set_slot(id, ~a, ~b, ~sub);
      n = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n++;
         if (bus.res_valid) begin lat = n; break; end
      end
   endtask

   task automatic consume();
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.res_valid); end
      checks++; if (bus.res_sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h want 0000", bus.res_sum); end
      checks++; if ({bus.res_cout, bus.res_ovf, bus.res_id} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {bus.res_cout, bus.res_ovf, bus.res_id}); end
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", bus.req_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      int lat;
      run_op(1'b0, 16'h1234, 16'h0FCD, 1'b0, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency: got %0d want 3", lat); end
      checks++; if (bus.res_sum !== 16'h2201) begin errors++; $display("FAIL add_sum: got %h want 2201", bus.res_sum); end
      checks++; if ({bus.res_cout, bus.res_ovf} !== 2'b00) begin errors++; $display("FAIL add_flags: got cout/ovf %b want 00", {bus.res_cout, bus.res_ovf}); end
      checks++; if (bus.res_id !== 1'b0) begin errors++; $display("FAIL add_id: got %b want 0", bus.res_id); end
      consume();
   endtask

   task automatic test_flags();
      int lat;
      run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL flags_pos_ovf_latency: got %0d want 3", lat); end
      checks++; if (bus.res_sum !== 16'h8000) begin errors++; $display("FAIL flags_pos_ovf_sum: got %h want 8000", bus.res_sum); end
      checks++; if ({bus.res_cout, bus.res_ovf} !== 2'b01) begin errors++; $display("FAIL flags_pos_ovf: got cout/ovf %b want 01", {bus.res_cout, bus.res_ovf}); end
      consume();
      run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, lat);
      checks++; if (bus.res_sum !== 16'h0000) begin errors++; $display("FAIL flags_wrap_sum: got %h want 0000", bus.res_sum); end
      checks++; if ({bus.res_cout, bus.res_ovf} !== 2'b10) begin errors++; $display("FAIL flags_wrap: got cout/ovf %b want 10", {bus.res_cout, bus.res_ovf}); end
      consume();
      run_op(1'b0, 16'h8000, 16'h0001, 1'b1, lat);
      checks++; if (bus.res_sum !== 16'h7FFF) begin errors++; $display("FAIL flags_neg_ovf_sum: got %h want 7fff", bus.res_sum); end
      checks++; if ({bus.res_cout, bus.res_ovf} !== 2'b11) begin errors++; $display("FAIL flags_neg_ovf: got cout/ovf %b want 11", {bus.res_cout, bus.res_ovf}); end
      consume();
   endtask

   task automatic test_sub();
      int lat;
      run_op(1'b1, 16'h0100, 16'h0001, 1'b1, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL sub_latency: got %0d want 3", lat); end
      checks++; if (bus.res_sum !== 16'h00FF) begin errors++; $display("FAIL sub_sum: got %h want 00ff", bus.res_sum); end
      checks++; if ({bus.res_cout, bus.res_ovf} !== 2'b10) begin errors++; $display("FAIL sub_flags: got cout/ovf %b want 10", {bus.res_cout, bus.res_ovf}); end
      checks++; if (bus.res_id !== 1'b1) begin errors++; $display("FAIL sub_id: got %b want 1", bus.res_id); end
      consume();
      // rr_ptr now points at 0; requester 1 alone must still be granted
      run_op(1'b1, 16'h0001, 16'h0002, 1'b1, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL sub_borrow_latency: got %0d want 3", lat); end
      checks++; if (bus.res_sum !== 16'hFFFF) begin errors++; $display("FAIL sub_borrow_sum: got %h want ffff", bus.res_sum); end
      checks++; if ({bus.res_cout, bus.res_ovf} !== 2'b00) begin errors++; $display("FAIL sub_borrow_flags: got cout/ovf %b want 00", {bus.res_cout, bus.res_ovf}); end
      checks++; if (bus.res_id !== 1'b1) begin errors++; $display("FAIL sub_borrow_id: got %b want 1", bus.res_id); end
      consume();
   endtask

   task automatic test_arbitration();
      int k, cyc, last;
      logic [W-1:0] exp_sum;
      @(posedge clk); #1;
      set_slot(1'b0, 16'h0010, 16'h0001, 1'b0);   // -> 0011
      set_slot(1'b1, 16'h0100, 16'h0020, 1'b1);   // -> 00e0
      bus.req_valid = 2'b11;
      bus.res_ready = 1'b1;
      k = 0; cyc = 0; last = 0;
      for (int c = 0; c < 60 && k < 4; c++) begin
         @(negedge clk);
         cyc++;
         checks++; if (bus.req_ready === 2'b11) begin errors++; $display("FAIL arb_ready_onehot: got %b want at most one bit", bus.req_ready); end
         if (bus.res_valid) begin
            exp_sum = k[0] ? 16'h00E0 : 16'h0011;
            checks++; if (bus.res_id !== k[0]) begin errors++; $display("FAIL arb_id[%0d]: got %b want %b", k, bus.res_id, k[0]); end
            checks++; if (bus.res_sum !== exp_sum) begin errors++; $display("FAIL arb_sum[%0d]: got %h want %h", k, bus.res_sum, exp_sum); end
            if (k > 0) begin
               checks++; if (cyc - last !== NB + 2) begin errors++; $display("FAIL arb_gap[%0d]: got %0d want %0d", k, cyc - last, NB + 2); end
            end
            last = cyc;
            k++;
         end
      end
      checks++; if (k !== 4) begin errors++; $display("FAIL arb_count: got %0d results want 4", k); end
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      bus.res_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      bit got;
      @(posedge clk); #1;
      set_slot(1'b0, 16'h1000, 16'h0234, 1'b0);   // -> 1234
      set_slot(1'b1, 16'h5555, 16'h1111, 1'b1);   // -> 4444, cout 1
      bus.req_valid = 2'b11;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (bus.res_valid) got = 1;
      end
      checks++; if (!got) begin errors++; $display("FAIL bp_first_valid: got timeout want res_valid"); end
      checks++; if (bus.res_id !== 1'b0) begin errors++; $display("FAIL bp_first_id: got %b want 0", bus.res_id); end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (bus.res_valid !== 1'b1 || bus.res_sum !== 16'h1234 || bus.res_id !== 1'b0 || bus.res_cout !== 1'b0 || bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got valid=%b sum=%h id=%b cout=%b ready=%b want 1/1234/0/0/00",
                     c, bus.res_valid, bus.res_sum, bus.res_id, bus.res_cout, bus.req_ready);
         end
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", bus.res_valid); end
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_grant: got %b want 10", bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (bus.res_valid) got = 1;
      end
      checks++; if (!got || bus.res_id !== 1'b1) begin errors++; $display("FAIL bp_second_id: got valid=%b id=%b want 1/1", got, bus.res_id); end
      checks++; if (bus.res_sum !== 16'h4444) begin errors++; $display("FAIL bp_second_sum: got %h want 4444", bus.res_sum); end
      checks++; if ({bus.res_cout, bus.res_ovf} !== 2'b10) begin errors++; $display("FAIL bp_second_flags: got cout/ovf %b want 10", {bus.res_cout, bus.res_ovf}); end
      consume();
   endtask

   task automatic test_reset_mid();
      int lat;
      bit stale;
      @(posedge clk); #1;
      set_slot(1'b0, 16'h1111, 16'h2222, 1'b0);
      bus.req_valid[0] = 1'b1;
      @(negedge clk);
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_grant: got %b want 01", bus.req_ready); end
      @(posedge clk); #1;            // handshake; pass 0 runs next
      bus.req_valid[0] = 1'b0;
      @(posedge clk); #1;            // now in pass 1
      rst_n = 1'b0;
      #1;
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", bus.res_valid); end
      checks++; if (bus.res_sum !== 16'h0000) begin errors++; $display("FAIL rstmid_sum: got %h want 0000", bus.res_sum); end
      checks++; if ({bus.res_cout, bus.res_ovf, bus.res_id} !== 3'b000) begin errors++; $display("FAIL rstmid_flags: got %b want 000", {bus.res_cout, bus.res_ovf, bus.res_id}); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.res_valid !== 1'b0) stale = 1;
      end
      checks++; if (stale) begin errors++; $display("FAIL rstmid_stale: got res_valid after reset want none"); end
      run_op(1'b0, 16'h0003, 16'h0004, 1'b0, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rstmid_next_latency: got %0d want 3", lat); end
      checks++; if (bus.res_sum !== 16'h0007) begin errors++; $display("FAIL rstmid_next_sum: got %h want 0007", bus.res_sum); end
      checks++; if (bus.res_id !== 1'b0) begin errors++; $display("FAIL rstmid_next_id: got %b want 0", bus.res_id); end
      consume();
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.req_valid = 2'b00;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_sub   = 2'b00;
      bus.res_ready = 1'b0;
      test_reset();
      test_add();
      test_flags();
      test_sub();
      test_arbitration();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
